// File: rtl/slice_pack_pkg.sv
// rtl/slice_pack_pkg.sv - shared state type and slot mapping for slice_packer
package slice_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Word position written by the idx-th slice of a word.
    function automatic int slot_of(input int idx, input bit msb_first, input int nslices);
        return msb_first ? (nslices - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/slice_pack_ctrl.sv
// rtl/slice_pack_ctrl.sv - fill/hold control, slice index and handshakes for slice_packer
module slice_pack_ctrl #(
    parameter int NSLICES   = 5,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = $clog2(NSLICES),
    parameter int CNT_W     = $clog2(NSLICES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             load,
    output logic             clear,
    output logic [IDX_W-1:0] slot
);
    import slice_pack_pkg::*;

    pack_state_e      state;
    pack_state_e      state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] filled;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            out_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        count_next = out_count;
        // Slices in the word once this cycle's accept is counted.
        filled     = CNT_W'(idx) + CNT_W'(load);
        last       = load && (idx == IDX_W'(NSLICES - 1));
        case (state)
            FILL: begin
                if (last || (flush && (filled != '0))) begin
                    state_next = HOLD;
                    idx_next   = '0;
                    count_next = filled;
                end else if (load) begin
                    idx_next = idx + 1'b1;
                end
            end
            HOLD: begin
                // A slice accepted alongside the handshake opens the next word.
                if (clear) begin
                    state_next = FILL;
                    idx_next   = load ? IDX_W'(1) : '0;
                    count_next = '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL) ? 1'b1 : out_ready;
        out_valid = (state == HOLD);
        load      = in_valid && in_ready;
        clear     = out_valid && out_ready;
        slot      = IDX_W'(slot_of(int'(idx), MSB_FIRST, NSLICES));
    end

endmodule

// File: rtl/slice_packer.sv
// rtl/slice_packer.sv - packs SLICE_W-bit slices into WORD_W-bit words on valid/ready ports
// Optional flush port enabled by defining SLICE_PACKER_FLUSH_EN.
module slice_packer #(
    parameter int WORD_W    = 10,
    parameter int SLICE_W   = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [SLICE_W-1:0]                      in_data,
`ifdef SLICE_PACKER_FLUSH_EN
    input  logic                                    flush,
`endif
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [WORD_W-1:0]                       out_data,
    output logic [$clog2(WORD_W / SLICE_W + 1)-1:0] out_count
);
    import slice_pack_pkg::*;

    localparam int NSLICES = WORD_W / SLICE_W;
    localparam int IDX_W   = $clog2(NSLICES);
    localparam int CNT_W   = $clog2(NSLICES + 1);
    localparam int BIT_W   = $clog2(WORD_W);

    generate
        if ((NSLICES < 2) || ((WORD_W % SLICE_W) != 0)) begin : g_bad_params
            $error("slice_packer: WORD_W must be a multiple of SLICE_W with at least 2 slices");
        end
    endgenerate

    logic                 load;
    logic                 clear;
    logic                 flush_req;
    logic [IDX_W-1:0]     slot;
    logic [BIT_W-1:0]     base;
    logic [WORD_W-1:0]    acc;
    logic [WORD_W-1:0]    acc_next;

`ifdef SLICE_PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    slice_pack_ctrl #(
        .NSLICES   (NSLICES),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .flush     (flush_req),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .load      (load),
        .clear     (clear),
        .slot      (slot)
    );

    assign base = BIT_W'(slot) * BIT_W'(SLICE_W);

    // Clearing on handshake keeps the previous word's bits out of the next one.
    always_comb begin
        acc_next = clear ? '0 : acc;
        if (load) begin
            acc_next[base +: SLICE_W] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_slice_packer.sv
// tb/tb_slice_packer.sv - randomized self-checking bench for slice_packer, LSB- and MSB-first side by side
module tb_slice_packer;
    localparam int WW = 10;
    localparam int SW = 2;
    localparam int NS = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush_r = 1'b0;
    logic [SW-1:0] in_data = '0;

    logic          in_ready_l, out_valid_l, in_ready_m, out_valid_m;
    logic [WW-1:0] data_l, data_m;
    logic [CW-1:0] count_l, count_m;

    int vectors = 0;
    int miscompares = 0;

    bit            m_valid;
    int            m_count;
    logic [WW-1:0] m_lsb, m_msb;
    int            q[$];

    always #5 clk = ~clk;

    slice_packer #(.WORD_W(WW), .SLICE_W(SW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
`ifdef SLICE_PACKER_FLUSH_EN
        .flush(flush_r),
`endif
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(data_l), .out_count(count_l)
    );

    slice_packer #(.WORD_W(WW), .SLICE_W(SW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
`ifdef SLICE_PACKER_FLUSH_EN
        .flush(flush_r),
`endif
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(data_m), .out_count(count_m)
    );

    task automatic model_reset();
        m_valid = 1'b0;
        m_count = 0;
        m_lsb   = '0;
        m_msb   = '0;
        q.delete();
    endtask

    task automatic apply(input bit v, input logic [SW-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush_r   = f;
        #1;
    endtask

    // Reference: collect accepted slices, emit a word when full or flushed while filling.
    task automatic advance();
        bit was_fill;
        bit acc;
        was_fill = !m_valid;
        acc = in_valid && (!m_valid || out_ready);
        if (m_valid && out_ready) m_valid = 1'b0;
        if (acc) q.push_back(int'(in_data));
        if (was_fill && ((q.size() == NS) || (flush_r && (q.size() > 0)))) begin
            m_lsb = '0;
            m_msb = '0;
            foreach (q[k]) begin
                logic [WW-1:0] s;
                s = WW'(q[k]);
                m_lsb = m_lsb | (s << (SW * k));
                m_msb = m_msb | (s << (SW * (NS - 1 - k)));
            end
            m_count = q.size();
            m_valid = 1'b1;
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        apply(1'b0, '0, 1'b1, 1'b0);
        repeat (2) advance();
    endtask

    task automatic test_reset();
        apply(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b%b want 00", out_valid_l, out_valid_m);
        end
        vectors++;
        if ({count_l, count_m} !== '0 || {data_l, data_m} !== '0) begin
            miscompares++;
            $display("FAIL reset_count_data: got count %0d/%0d data %h/%h want 0", count_l, count_m, data_l, data_m);
        end
        rst_n = 1'b1;
        model_reset();
        advance();
        vectors++;
        if ({in_ready_l, in_ready_m} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b%b want 11", in_ready_l, in_ready_m);
        end
    endtask

    task automatic test_lsb_msb_first();
        logic [SW-1:0] d [NS];
        d = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < NS; i++) begin
            apply(1'b1, d[i], 1'b1, 1'b0);
            vectors++;
            if ({out_valid_l, out_valid_m} !== 2'b00) begin
                miscompares++;
                $display("FAIL early_valid slice %0d: got %b%b want 00", i, out_valid_l, out_valid_m);
            end
            advance();
        end
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== 10'h139 || data_m !== 10'h1B1) begin
            miscompares++;
            $display("FAIL word_12301: got v=%b%b %h/%h want v=11 139/1b1", out_valid_l, out_valid_m, data_l, data_m);
        end
        vectors++;
        if (count_l !== CW'(NS) || count_m !== CW'(NS)) begin
            miscompares++;
            $display("FAIL word_12301_count: got %0d/%0d want %0d", count_l, count_m, NS);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * NS; i++) begin
            apply(1'b1, (i < NS) ? 2'd3 : 2'd0, 1'b1, 1'b0);
            vectors++;
            if ({in_ready_l, in_ready_m} !== 2'b11) begin
                miscompares++;
                $display("FAIL stream_in_ready cycle %0d: got %b%b want 11", i, in_ready_l, in_ready_m);
            end
            advance();
            if (i == NS - 1 || i == 2 * NS - 1) begin
                vectors++;
                if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== ((i < NS) ? 10'h3FF : 10'h000)
                    || data_m !== ((i < NS) ? 10'h3FF : 10'h000)) begin
                    miscompares++;
                    $display("FAIL stream_word %0d: got v=%b%b %h/%h want v=11 %h", i / NS, out_valid_l,
                             out_valid_m, data_l, data_m, (i < NS) ? 10'h3FF : 10'h000);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] nd [NS];
        for (int i = 0; i < NS; i++) begin
            apply(1'b1, SW'($urandom_range(0, 3)), 1'b1, 1'b0);
            advance();
        end
        for (int i = 0; i < NS; i++) nd[i] = SW'($urandom_range(0, 3));
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, nd[0], 1'b0, 1'b0);
            vectors++;
            if ({in_ready_l, in_ready_m, out_valid_l, out_valid_m} !== 4'b0011 || data_l !== m_lsb || data_m !== m_msb) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got rdy=%b%b v=%b%b %h/%h want rdy=00 v=11 %h/%h", c, in_ready_l,
                         in_ready_m, out_valid_l, out_valid_m, data_l, data_m, m_lsb, m_msb);
            end
            advance();
        end
        for (int i = 0; i < NS; i++) begin
            apply(1'b1, nd[i], 1'b1, 1'b0);
            advance();
        end
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== m_lsb || data_m !== m_msb) begin
            miscompares++;
            $display("FAIL after_stall_word: got v=%b%b %h/%h want v=11 %h/%h", out_valid_l, out_valid_m,
                     data_l, data_m, m_lsb, m_msb);
        end
        drain();
    endtask

`ifdef SLICE_PACKER_FLUSH_EN
    task automatic test_flush();
        apply(1'b1, 2'd3, 1'b0, 1'b0); advance();
        apply(1'b1, 2'd3, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b1); advance();
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== 10'h00F || data_m !== 10'h3C0
            || count_l !== 3'd2 || count_m !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_partial: got v=%b%b %h/%h cnt %0d/%0d want v=11 00f/3c0 cnt 2", out_valid_l,
                     out_valid_m, data_l, data_m, count_l, count_m);
        end
        apply(1'b0, '0, 1'b0, 1'b1); advance();
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || count_l !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_in_hold: got v=%b%b cnt %0d want v=11 cnt 2", out_valid_l, out_valid_m, count_l);
        end
        apply(1'b0, '0, 1'b1, 1'b0); advance();
        apply(1'b0, '0, 1'b1, 1'b1); advance();
        apply(1'b0, '0, 1'b1, 1'b0); advance();
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_empty: got v=%b%b want 00", out_valid_l, out_valid_m);
        end
        for (int i = 0; i < NS; i++) begin
            apply(1'b1, 2'd1, 1'b1, i == NS - 1);
            advance();
        end
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== 10'h155 || count_l !== CW'(NS)) begin
            miscompares++;
            $display("FAIL flush_on_last: got v=%b%b %h cnt %0d want v=11 155 cnt %0d", out_valid_l, out_valid_m,
                     data_l, count_l, NS);
        end
        drain();
    endtask
`endif

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, SW'($urandom_range(0, 3)), 1'b1, 1'b0);
            advance();
        end
        rst_n = 1'b0;
        apply(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b00 || {count_l, count_m} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b%b cnt %0d/%0d want v=00 cnt 0", out_valid_l, out_valid_m, count_l, count_m);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) begin
            apply(1'b1, 2'd2, 1'b1, 1'b0);
            advance();
        end
        vectors++;
        if ({out_valid_l, out_valid_m} !== 2'b11 || data_l !== 10'h2AA || data_m !== 10'h2AA) begin
            miscompares++;
            $display("FAIL post_reset_word: got v=%b%b %h/%h want v=11 2aa/2aa", out_valid_l, out_valid_m, data_l, data_m);
        end
        drain();
    endtask

    task automatic test_random();
        bit f;
        for (int c = 0; c < 400; c++) begin
            f = 1'b0;
`ifdef SLICE_PACKER_FLUSH_EN
            f = ($urandom_range(0, 7) == 0);
`endif
            apply($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, f);
            vectors++;
            if (in_ready_l !== (!m_valid || out_ready) || in_ready_m !== (!m_valid || out_ready)
                || out_valid_l !== m_valid || out_valid_m !== m_valid) begin
                miscompares++;
                $display("FAIL rand_hs cycle %0d: got rdy=%b%b v=%b%b want rdy=%b v=%b", c, in_ready_l, in_ready_m,
                         out_valid_l, out_valid_m, !m_valid || out_ready, m_valid);
            end
            if (m_valid) begin
                vectors++;
                if (data_l !== m_lsb || data_m !== m_msb || count_l !== CW'(m_count) || count_m !== CW'(m_count)) begin
                    miscompares++;
                    $display("FAIL rand_word cycle %0d: got %h/%h cnt %0d/%0d want %h/%h cnt %0d", c, data_l, data_m,
                             count_l, count_m, m_lsb, m_msb, m_count);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_lsb_msb_first();
        test_back_to_back();
        test_backpressure();
`ifdef SLICE_PACKER_FLUSH_EN
        test_flush();
`endif
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
